// File: rtl/sum_pkg.sv
// sum_pkg: shared state encoding, defaults and index-width helper for sum_seq_ctrl
package sum_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_WORDS = 4;
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction
  localparam int DEF_IDX_W = idx_w(DEF_WORDS);
endpackage

// File: rtl/sum_seq_ctrl_if.sv
// sum_seq_ctrl_if: operand/result handshake bundle; sub exists only with SUM_SUB_EN
interface sum_seq_ctrl_if #(parameter int WIDTH = 4, parameter int WORDS = 4);
  logic in_valid;
  logic in_ready;
  logic [WIDTH*WORDS-1:0] data_a;
  logic [WIDTH*WORDS-1:0] data_b;
`ifdef SUM_SUB_EN
  logic sub;
`endif
  logic out_valid;
  logic out_ready;
  logic [WIDTH*WORDS-1:0] sum;
  logic c_out;
  logic busy;
  modport master (
    output in_valid, data_a, data_b, out_ready,
`ifdef SUM_SUB_EN
    output sub,
`endif
    input in_ready, out_valid, sum, c_out, busy
  );
  modport slave (
    input in_valid, data_a, data_b, out_ready,
`ifdef SUM_SUB_EN
    input sub,
`endif
    output in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/slice_adder.sv
// slice_adder: WIDTH-bit ripple-carry chain of full_adder cells
module slice_adder #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  logic [WIDTH:0] c;
  assign c[0]  = c_in;
  assign c_out = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .c_in(c[i]), .sum(sum[i]), .c_out(c[i+1]));
  end
endmodule

// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: wide add sequenced one WIDTH chunk per cycle through one slice_adder.
// Define SUM_SUB_EN to add a sub input that turns the operation into A - B.
module sum_seq_ctrl
  import sum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input logic clk,
  input logic rst,
  sum_seq_ctrl_if.slave bus
);
  localparam int IW = idx_w(WORDS);
  localparam int N  = WIDTH * WORDS;
  state_t         state;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [N-1:0]   op_a, op_b, sum_r;
  logic           c_out_r, out_valid_r, in_ready_r, busy_r;
  logic [WIDTH-1:0] ca, cb, cs;
  logic           cc;
  logic           last;
  assign ca   = op_a[idx*WIDTH +: WIDTH];
  assign cb   = op_b[idx*WIDTH +: WIDTH];
  assign last = (idx == IW'(WORDS - 1));
  slice_adder #(.WIDTH(WIDTH)) u_slice (.a(ca), .b(cb), .c_in(carry), .sum(cs), .c_out(cc));
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      sum_r       <= '0;
      c_out_r     <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && in_ready_r) begin
          op_a       <= bus.data_a;
`ifdef SUM_SUB_EN
          op_b       <= bus.sub ? ~bus.data_b : bus.data_b;
          carry      <= bus.sub;
`else
          op_b       <= bus.data_b;
          carry      <= 1'b0;
`endif
          idx        <= '0;
          sum_r      <= '0;
          state      <= RUN;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b1;
        end
        RUN: begin
          sum_r[idx*WIDTH +: WIDTH] <= cs;
          carry <= cc;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            c_out_r     <= cc;
            state       <= DONE;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        DONE: if (out_valid_r && bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_sum_seq_ctrl.sv
// tb_sum_seq_ctrl: directed self-checking bench for sum_seq_ctrl (WIDTH=4, WORDS=4)
module tb_sum_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic sub_q = 1'b0;
  sum_seq_ctrl_if #(.WIDTH(4), .WORDS(4)) bus ();
  sum_seq_ctrl #(.WIDTH(4), .WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
`ifdef SUM_SUB_EN
  assign bus.sub = sub_q;
`endif
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus.in_valid = 1'b1;
    bus.data_a   = a;
    bus.data_b   = b;
    sub_q        = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat, output logic rdy_seen, output logic busy_low);
    lat = 0;
    rdy_seen = 1'b0;
    busy_low = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      rdy_seen |= bus.in_ready;
      busy_low |= ~bus.busy;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.data_a = '0; bus.data_b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum got %h want 0000", bus.sum); end
    n_cmp++; if (bus.c_out !== 1'b0) begin n_err++; $display("FAIL reset_c_out got %b want 0", bus.c_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic();
    int lat; logic rs, bl;
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_done(lat, rs, bl);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency got %0d want 4", lat); end
    n_cmp++; if (rs !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_run got %b want 0", rs); end
    n_cmp++; if (bl !== 1'b0) begin n_err++; $display("FAIL basic_busy_run got low=%b want 0", bl); end
    n_cmp++; if (bus.sum !== 16'h5555) begin n_err++; $display("FAIL basic_sum got %h want 5555", bus.sum); end
    n_cmp++; if (bus.c_out !== 1'b0) begin n_err++; $display("FAIL basic_c_out got %b want 0", bus.c_out); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_done got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got %b want 0", bus.busy); end
    consume();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_release_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_release_ready got %b want 1", bus.in_ready); end
  endtask
  task automatic test_vectors();
    logic [15:0] va [5] = '{16'hFFFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h0000};
    logic [15:0] vb [5] = '{16'h0001, 16'h8000, 16'hF0F1, 16'h1111, 16'h0000};
    logic [15:0] vs [5] = '{16'h0000, 16'h0000, 16'h0000, 16'hBCDE, 16'h0000};
    logic        vc [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat; logic rs, bl;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], 1'b0);
      wait_done(lat, rs, bl);
      n_cmp++; if (bus.sum !== vs[i]) begin n_err++; $display("FAIL vec%0d_sum got %h want %h", i, bus.sum, vs[i]); end
      n_cmp++; if (bus.c_out !== vc[i]) begin n_err++; $display("FAIL vec%0d_c_out got %b want %b", i, bus.c_out, vc[i]); end
      consume();
    end
  endtask
  task automatic test_hold();
    int lat; logic rs, bl;
    start_op(16'h00F0, 16'h0010, 1'b0);
    wait_done(lat, rs, bl);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.data_a = 16'h1111; bus.data_b = 16'h2222;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL hold%0d_valid got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.sum !== 16'h0100) begin n_err++; $display("FAIL hold%0d_sum got %h want 0100", i, bus.sum); end
      n_cmp++; if (bus.c_out !== 1'b0) begin n_err++; $display("FAIL hold%0d_c_out got %b want 0", i, bus.c_out); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_in_ready got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    consume();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got %b want 1", bus.in_ready); end
  endtask
  task automatic test_ignore();
    int lat; logic rs, bl;
    start_op(16'h0001, 16'h0001, 1'b0);
    bus.in_valid = 1'b1; bus.data_a = 16'hAAAA; bus.data_b = 16'h1111;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.data_a = 16'hFFFF; bus.data_b = 16'hFFFF;
    wait_done(lat, rs, bl);
    n_cmp++; if (bus.sum !== 16'h0002) begin n_err++; $display("FAIL ignore_sum got %h want 0002", bus.sum); end
    n_cmp++; if (bus.c_out !== 1'b0) begin n_err++; $display("FAIL ignore_c_out got %b want 0", bus.c_out); end
    consume();
    start_op(16'hAAAA, 16'h1111, 1'b0);
    wait_done(lat, rs, bl);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL ignore_next_latency got %0d want 4", lat); end
    n_cmp++; if (bus.sum !== 16'hBBBB) begin n_err++; $display("FAIL ignore_next_sum got %h want BBBB", bus.sum); end
    consume();
  endtask
  task automatic test_reset_mid();
    logic seen = 1'b0;
    start_op(16'h8888, 16'h8888, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL midrst_sum got %h want 0000", bus.sum); end
    n_cmp++; if (bus.c_out !== 1'b0) begin n_err++; $display("FAIL midrst_c_out got %b want 0", bus.c_out); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    repeat (8) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_result got %b want 0", seen); end
  endtask
  task automatic test_back_to_back();
    int hits = 0;
    logic bad_sum = 1'b0;
    bus.in_valid = 1'b1; bus.data_a = 16'h0001; bus.data_b = 16'h0002; bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        hits++;
        bad_sum |= (bus.sum !== 16'h0003);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_cmp++; if (hits !== 2) begin n_err++; $display("FAIL b2b_results got %0d want 2", hits); end
    n_cmp++; if (bad_sum !== 1'b0) begin n_err++; $display("FAIL b2b_sum got bad=%b want 0", bad_sum); end
    @(negedge clk);
  endtask
`ifdef SUM_SUB_EN
  task automatic test_sub();
    int lat; logic rs, bl;
    start_op(16'h0005, 16'h0003, 1'b1);
    wait_done(lat, rs, bl);
    n_cmp++; if (bus.sum !== 16'h0002) begin n_err++; $display("FAIL sub1_sum got %h want 0002", bus.sum); end
    n_cmp++; if (bus.c_out !== 1'b1) begin n_err++; $display("FAIL sub1_c_out got %b want 1", bus.c_out); end
    consume();
    start_op(16'h0003, 16'h0005, 1'b1);
    wait_done(lat, rs, bl);
    n_cmp++; if (bus.sum !== 16'hFFFE) begin n_err++; $display("FAIL sub2_sum got %h want FFFE", bus.sum); end
    n_cmp++; if (bus.c_out !== 1'b0) begin n_err++; $display("FAIL sub2_c_out got %b want 0", bus.c_out); end
    consume();
    start_op(16'h0003, 16'h0005, 1'b0);
    wait_done(lat, rs, bl);
    n_cmp++; if (bus.sum !== 16'h0008) begin n_err++; $display("FAIL sub0_sum got %h want 0008", bus.sum); end
    consume();
  endtask
`endif
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_hold();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef SUM_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
